ob_serializer: RTL

- Output buffer: parallel-in, serial-out. The complement of the serial-in/parallel-out input buffer.
- Captures one packed vector of `vector` results from the compute array in a single cycle.
- Streams the vector out one element per cycle under a valid/ready handshake, element 0 first.
- A shadow register allows the next vector to be loaded while the current one drains, so back-to-back vectors stream without bubbles.

---
 rtl/ob_serializer_if.sv | 29 ++
 rtl/ob_serializer.sv | 82 ++++++++
 2 files changed

// File: rtl/ob_serializer_if.sv
// Handshake/bus bundle for ob_serializer: parallel load side and serial output side.
// out_last exists only when OB_LAST_EN is defined.
interface ob_serializer_if #(
    parameter int width  = 8,
    parameter int vector = 4
);
    logic                    clr;
    logic                    load;
    logic [vector*width-1:0] pin;
    logic                    load_ready;
    logic [width-1:0]        out;
    logic                    out_valid;
    logic                    out_ready;
    logic [7:0]              addr;
    logic                    busy;
`ifdef OB_LAST_EN
    logic                    out_last;

    modport slave  (input  clr, load, pin, out_ready,
                    output load_ready, out, out_valid, addr, busy, out_last);
    modport master (output clr, load, pin, out_ready,
                    input  load_ready, out, out_valid, addr, busy, out_last);
`else
    modport slave  (input  clr, load, pin, out_ready,
                    output load_ready, out, out_valid, addr, busy);
    modport master (output clr, load, pin, out_ready,
                    input  load_ready, out, out_valid, addr, busy);
`endif
endinterface

// File: rtl/ob_serializer.sv
// Parallel-in serial-out output buffer with shadow bank; OB_LAST_EN adds out_last.
// Latency: load edge N -> first element valid after edge N+1; back-to-back vectors stream bubble-free.
// Backpressure: out_ready=0 holds out/addr; load_ready=0 while the shadow bank is occupied.
module ob_serializer #(
    parameter int width  = 8,
    parameter int vector = 4
) (
    input  logic            clk,
    input  logic            rst,
    ob_serializer_if.slave  bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [7:0] LAST_ADDR = 8'(vector - 1);

    state_t                  state, nxt_state;
    logic [vector*width-1:0] shadow, active;
    logic                    shadow_full;
    logic [7:0]              addr_q;
    logic                    hs, last, take, accept;

    assign hs     = (state == SHIFT) && bus.out_ready;
    assign last   = (addr_q == LAST_ADDR);
    // Shadow moves to active either to start from idle or to chain straight after the last element.
    assign take   = shadow_full && ((state == IDLE) || (hs && last));
    assign accept = bus.load && !shadow_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        if (bus.clr) begin
            nxt_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (shadow_full)               nxt_state = SHIFT;
                SHIFT:   if (hs && last && !shadow_full) nxt_state = IDLE;
                default: nxt_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow      <= '0;
            active      <= '0;
            shadow_full <= 1'b0;
            addr_q      <= 8'd0;
        end else if (bus.clr) begin
            shadow_full <= 1'b0;
            addr_q      <= 8'd0;
        end else begin
            if (take) begin
                active <= shadow;
                addr_q <= 8'd0;
            end else if (hs) begin
                addr_q <= last ? 8'd0 : addr_q + 8'd1;
            end
            if (accept) begin
                shadow      <= bus.pin;
                shadow_full <= 1'b1;
            end else if (take) begin
                shadow_full <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.out_valid  = (state == SHIFT);
        bus.out        = '0;
        if (state == SHIFT) bus.out = active[int'(addr_q)*width +: width];
        bus.addr       = addr_q;
        bus.busy       = (state == SHIFT) || shadow_full;
        bus.load_ready = !shadow_full;
`ifdef OB_LAST_EN
        bus.out_last   = (state == SHIFT) && last;
`endif
    end
endmodule
